// File: rtl/filter_phase_ctrl.sv
// filter_phase_ctrl: two-phase non-overlapping clock generator and sample/event
// reader for the switched-cap filter macro.
// Optional feature macro: FILTER_EVENT_CNT_EN (polxevent synchroniser, edge
// detector and saturating event counter). Without it event_count reads 0 and
// cnt_clr/polxevent are ignored.
module filter_phase_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned GAP_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             enable,
  input  logic [DIV_W-1:0] half_period,
  input  logic [GAP_W-1:0] gap,
  input  logic             cnt_clr,
  input  logic             compout,
  input  logic             pol,
  input  logic             polxevent,
  output logic             phi1,
  output logic             phi2,
  output logic             phi1b,
  output logic             phi2b,
  output logic             busy,
  output logic             sample_valid,
  output logic             sample_cmp,
  output logic             sample_pol,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned CW = (DIV_W > GAP_W) ? DIV_W : GAP_W;

  typedef enum logic [2:0] {StIdle, StP1, StG12, StP2, StG21} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  // Shadow config stored as (length - 1) so a zero setting behaves as 1.
  logic [DIV_W-1:0] hp_m1_q;
  logic [GAP_W-1:0] g_m1_q;
  logic [DIV_W-1:0] hp_in_m1;
  logic [GAP_W-1:0] g_in_m1;

  logic cmp_s1_q, cmp_s2_q;
  logic pol_s1_q, pol_s2_q;

  // Convert raw config into minus-one form, clamping 0 to a length of 1.
  always_comb begin
    hp_in_m1 = '0;
    g_in_m1  = '0;
    if (half_period != '0) hp_in_m1 = half_period - DIV_W'(1);
    if (gap != '0)         g_in_m1  = gap - GAP_W'(1);
  end

  // Two-flop synchronisers for the asynchronous comparator and polarity outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
      pol_s1_q <= 1'b0;
      pol_s2_q <= 1'b0;
    end else begin
      cmp_s1_q <= compout;
      cmp_s2_q <= cmp_s1_q;
      pol_s1_q <= pol;
      pol_s2_q <= pol_s1_q;
    end
  end

  // Phase FSM with registered phase, busy and sample outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hp_m1_q      <= '0;
      g_m1_q       <= '0;
      phi1         <= 1'b0;
      phi2         <= 1'b0;
      phi1b        <= 1'b1;
      phi2b        <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_cmp   <= 1'b0;
      sample_pol   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            hp_m1_q <= hp_in_m1;
            g_m1_q  <= g_in_m1;
            cnt_q   <= CW'(hp_in_m1);
            state_q <= StP1;
            phi1    <= 1'b1;
            phi1b   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StP1: begin
          if (cnt_q == '0) begin
            state_q <= StG12;
            cnt_q   <= CW'(g_m1_q);
            phi1    <= 1'b0;
            phi1b   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StG12: begin
          if (cnt_q == '0) begin
            state_q <= StP2;
            cnt_q   <= CW'(hp_m1_q);
            phi2    <= 1'b1;
            phi2b   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StP2: begin
          if (cnt_q == '0) begin
            // Capture on the last phi2 cycle; strobe lands in the first G21 cycle.
            state_q      <= StG21;
            cnt_q        <= CW'(g_m1_q);
            phi2         <= 1'b0;
            phi2b        <= 1'b1;
            sample_cmp   <= cmp_s2_q;
            sample_pol   <= pol_s2_q;
            sample_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StG21: begin
          if (cnt_q == '0) begin
            if (enable) begin
              hp_m1_q <= hp_in_m1;
              g_m1_q  <= g_in_m1;
              cnt_q   <= CW'(hp_in_m1);
              state_q <= StP1;
              phi1    <= 1'b1;
              phi1b   <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          phi1    <= 1'b0;
          phi2    <= 1'b0;
          phi1b   <= 1'b1;
          phi2b   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FILTER_EVENT_CNT_EN
  logic             pe_s1_q, pe_s2_q, pe_d_q;
  logic [CNT_W-1:0] evt_cnt_q;
  logic             pe_rise;

  assign pe_rise     = pe_s2_q & ~pe_d_q;
  assign event_count = evt_cnt_q;

  // Synchronise polxevent and count its rising edges, saturating; clear wins.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      pe_s1_q   <= 1'b0;
      pe_s2_q   <= 1'b0;
      pe_d_q    <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      pe_s1_q <= polxevent;
      pe_s2_q <= pe_s1_q;
      pe_d_q  <= pe_s2_q;
      if (cnt_clr) begin
        evt_cnt_q <= '0;
      end else if (pe_rise && (evt_cnt_q != {CNT_W{1'b1}})) begin
        evt_cnt_q <= evt_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic unused_evt_inputs;
  assign unused_evt_inputs = cnt_clr ^ polxevent;
  assign event_count       = '0;
`endif

endmodule

// File: tb/tb_filter_phase_ctrl.sv
// Directed bench for filter_phase_ctrl: idle/reset state, phase timing for
// several configs, sampling, mid-period enable/config changes, event counting
// (when FILTER_EVENT_CNT_EN is defined) and asynchronous reset.
module tb_filter_phase_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  half_period = 8'd0;
  logic [3:0]  gap = 4'd0;
  logic        cnt_clr = 1'b0;
  logic        compout = 1'b0;
  logic        pol = 1'b0;
  logic        polxevent = 1'b0;
  logic        phi1, phi2, phi1b, phi2b, busy, sample_valid, sample_cmp, sample_pol;
  logic [15:0] event_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  filter_phase_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .enable      (enable),
    .half_period (half_period),
    .gap         (gap),
    .cnt_clr     (cnt_clr),
    .compout     (compout),
    .pol         (pol),
    .polxevent   (polxevent),
    .phi1        (phi1),
    .phi2        (phi2),
    .phi1b       (phi1b),
    .phi2b       (phi2b),
    .busy        (busy),
    .sample_valid(sample_valid),
    .sample_cmp  (sample_cmp),
    .sample_pol  (sample_pol),
    .event_count (event_count)
  );

`ifdef FILTER_EVENT_CNT_EN
  logic p1_s, p2_s, p1b_s, p2b_s, busy_s, sv_s, sc_s, sp_s;
  logic [1:0] event_count_s;

  filter_phase_ctrl #(.CNT_W(2)) dut_small (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .enable      (1'b0),
    .half_period (half_period),
    .gap         (gap),
    .cnt_clr     (cnt_clr),
    .compout     (compout),
    .pol         (pol),
    .polxevent   (polxevent),
    .phi1        (p1_s),
    .phi2        (p2_s),
    .phi1b       (p1b_s),
    .phi2b       (p2b_s),
    .busy        (busy_s),
    .sample_valid(sv_s),
    .sample_cmp  (sc_s),
    .sample_pol  (sp_s),
    .event_count (event_count_s)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_phases(input string tag, input logic e1, input logic e2);
    chk({tag, "_phi1"}, {31'd0, phi1}, {31'd0, e1});
    chk({tag, "_phi2"}, {31'd0, phi2}, {31'd0, e2});
    chk({tag, "_phi1b"}, {31'd0, phi1b}, {31'd0, ~e1});
    chk({tag, "_phi2b"}, {31'd0, phi2b}, {31'd0, ~e2});
    chk({tag, "_overlap"}, {31'd0, phi1 & phi2}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset with enable low, then hold idle for 20 cycles.
    compout = 1'b1;
    pol     = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_phases("idle", 1'b0, 1'b0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_sv", {31'd0, sample_valid}, 32'd0);
      chk("idle_cnt", {16'd0, event_count}, 32'd0);
    end
    chk("idle_scmp", {31'd0, sample_cmp}, 32'd0);

    // hp=3, g=2: period 10, phi1 steps 0-2, phi2 steps 5-7, sample strobe step 8.
    half_period = 8'd3;
    gap         = 4'd2;
    enable      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_phases("hp3", (i % 10) < 3, ((i % 10) >= 5) && ((i % 10) <= 7));
      chk("hp3_busy", {31'd0, busy}, 32'd1);
      chk("hp3_sv", {31'd0, sample_valid}, {31'd0, (i % 10) == 8});
      if ((i % 10) == 8) begin
        chk("hp3_scmp", {31'd0, sample_cmp}, 32'd1);
        chk("hp3_spol", {31'd0, sample_pol}, 32'd0);
      end
    end
    enable = 1'b0;
    wait_idle("hp3");
    chk_phases("hp3_end", 1'b0, 1'b0);

    // hp=0, g=0 behave as 1/1: period 4.
    half_period = 8'd0;
    gap         = 4'd0;
    enable      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_phases("hp0", (i % 4) == 0, (i % 4) == 2);
      chk("hp0_sv", {31'd0, sample_valid}, {31'd0, (i % 4) == 3});
    end
    enable = 1'b0;
    wait_idle("hp0");

    // hp=2, g=1; hp changed to 5 in first P1 (applies at next P1), enable dropped
    // during the second period's P1 so that period completes, then idle.
    half_period = 8'd2;
    gap         = 4'd1;
    enable      = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk_phases("mid", (k <= 2) || (k >= 7 && k <= 11),
                 (k == 4) || (k == 5) || (k >= 13 && k <= 17));
      chk("mid_busy", {31'd0, busy}, {31'd0, k <= 18});
      chk("mid_sv", {31'd0, sample_valid}, {31'd0, (k == 6) || (k == 18)});
      if (k == 1) half_period = 8'd5;
      if (k == 7) enable = 1'b0;
    end

    // Event counting: five polxevent pulses.
    for (int p = 0; p < 5; p++) begin
      polxevent = 1'b1;
      repeat (2) tick();
      polxevent = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
`ifdef FILTER_EVENT_CNT_EN
    chk("evt_count5", {16'd0, event_count}, 32'd5);
    chk("evt_sat", {30'd0, event_count_s}, 32'd3);
    // Clear coincident with the counted edge.
    polxevent = 1'b1;
    repeat (2) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("evt_clr", {16'd0, event_count}, 32'd0);
    chk("evt_clr_small", {30'd0, event_count_s}, 32'd0);
    repeat (3) tick();
    polxevent = 1'b0;
    repeat (3) tick();
    chk("evt_after_clr", {16'd0, event_count}, 32'd0);
`else
    chk("evt_disabled", {16'd0, event_count}, 32'd0);
`endif

    // Async reset in the middle of P2.
    compout     = 1'b1;
    half_period = 8'd3;
    gap         = 4'd2;
    enable      = 1'b1;
    repeat (6) tick();
    chk("pre_rst_phi2", {31'd0, phi2}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_phases("rst", 1'b0, 1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sv", {31'd0, sample_valid}, 32'd0);
    chk("rst_scmp", {31'd0, sample_cmp}, 32'd0);
    chk("rst_spol", {31'd0, sample_pol}, 32'd0);
    chk("rst_cnt", {16'd0, event_count}, 32'd0);
    enable = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
